// File: rtl/ssp_cmu_pkg.sv
// Shared types, defaults and helpers for the SSP clock-management blocks.
// The phase generator and the clear stretcher both import this package.
package ssp_cmu_pkg;

  localparam int unsigned DEF_NUM_PHASES    = 2;
  localparam int unsigned DEF_CNT_W         = 8;
  localparam int unsigned DEF_DEAD_W        = 4;
  localparam int unsigned DEF_NUM_INTR      = 2;
  localparam int unsigned DEF_STALL_BIT     = 1;
  localparam int unsigned DEF_CLEAR_STRETCH = 4;

  // Upper bound on phase count that onehot() can encode.
  localparam int unsigned MAX_PHASES = 32;
  localparam int unsigned OH_IDX_W   = $clog2(MAX_PHASES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DEAD   = 2'd2
  } phase_state_e;

  // Decode a phase index into a one-hot strobe vector; callers truncate to NUM_PHASES.
  function automatic logic [MAX_PHASES-1:0] onehot(input logic [OH_IDX_W-1:0] idx);
    logic [MAX_PHASES-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage : ssp_cmu_pkg

// File: rtl/ssp_clear_stretch.sv
// Stretches the synchronous clear so downstream blocks see it for
// STRETCH extra cycles after the source clear drops.
module ssp_clear_stretch
  import ssp_cmu_pkg::*;
#(
  parameter int unsigned STRETCH = DEF_CLEAR_STRETCH
) (
  input  logic clk_i,
  input  logic clear_i,
  output logic clear_o
);

  localparam int unsigned SCNT_W = $clog2(STRETCH + 1);

  logic [SCNT_W-1:0] cnt_q;
  logic [SCNT_W-1:0] cnt_d;
  logic              clear_q;
  logic              clear_d;

  // Reload while the source clear is high, then count down holding the output high.
  always_comb begin
    cnt_d   = cnt_q;
    clear_d = 1'b0;
    if (clear_i) begin
      cnt_d   = SCNT_W'(STRETCH);
      clear_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d   = cnt_q - SCNT_W'(1);
      clear_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q   <= cnt_d;
    clear_q <= clear_d;
  end

  assign clear_o = clear_q;

endmodule : ssp_clear_stretch

// File: rtl/ssp_phase_gen.sv
// Multi-phase non-overlapping clock-enable generator for the SSP datapath,
// with programmable phase width, dead time, interrupt-driven stall and stretched clear.
module ssp_phase_gen
  import ssp_cmu_pkg::*;
#(
  parameter int unsigned NUM_PHASES    = DEF_NUM_PHASES,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned DEAD_W        = DEF_DEAD_W,
  parameter int unsigned NUM_INTR      = DEF_NUM_INTR,
  parameter int unsigned STALL_BIT     = DEF_STALL_BIT,
  parameter int unsigned CLEAR_STRETCH = DEF_CLEAR_STRETCH,
  localparam int unsigned IDX_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [CNT_W-1:0]      div_i,
  input  logic [DEAD_W-1:0]     dead_i,
  input  logic [NUM_INTR-1:0]   ssp_intr_i,
  output logic [NUM_PHASES-1:0] phi_o,
  output logic [IDX_W-1:0]      phase_idx_o,
  output logic                  cycle_done_o,
  output logic                  stalled_o,
  output logic                  clk_o,
  output logic                  clear_o
);

  phase_state_e          state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      div_q;
  logic [DEAD_W-1:0]     dcnt_q;
  logic [DEAD_W-1:0]     dead_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_PHASES-1:0] phi_q;
  logic                  done_q;
  logic                  stalled_q;

  logic                  stall_c;
  logic                  last_phase_c;
  logic                  phase_end_c;
  logic                  dead_end_c;
  logic [IDX_W-1:0]      next_idx_c;
  logic                  unused_intr;

  assign stall_c      = ssp_intr_i[STALL_BIT];
  assign unused_intr  = ^ssp_intr_i;
  assign last_phase_c = (idx_q == IDX_W'(NUM_PHASES - 1));
  assign next_idx_c   = last_phase_c ? '0 : idx_q + IDX_W'(1);
  // Full-width compares: div_i all-ones runs 2^CNT_W cycles with no counter wrap.
  assign phase_end_c  = (cnt_q == div_q);
  assign dead_end_c   = (dcnt_q == dead_q - DEAD_W'(1));

  // Sequencer: stall freezes all state and takes priority over any transition.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      dcnt_q    <= '0;
      dead_q    <= '0;
      idx_q     <= '0;
      phi_q     <= '0;
      done_q    <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      stalled_q <= stall_c && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          phi_q <= '0;
          if (en_i && !stall_c) begin
            state_q <= ACTIVE;
            idx_q   <= '0;
            cnt_q   <= '0;
            div_q   <= div_i;
            dead_q  <= dead_i;
            phi_q   <= NUM_PHASES'(onehot('0));
          end
        end
        ACTIVE: begin
          if (!stall_c) begin
            if (!phase_end_c) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              cnt_q  <= '0;
              idx_q  <= next_idx_c;
              done_q <= last_phase_c;
              if (last_phase_c && !en_i) begin
                state_q <= IDLE;
                phi_q   <= '0;
              end else if (dead_q != '0) begin
                state_q <= DEAD;
                dcnt_q  <= '0;
                phi_q   <= '0;
              end else begin
                // Back-to-back phases: strobes swap on this edge.
                div_q  <= div_i;
                dead_q <= dead_i;
                phi_q  <= NUM_PHASES'(onehot(OH_IDX_W'(next_idx_c)));
              end
            end
          end
        end
        DEAD: begin
          if (!stall_c) begin
            if (!dead_end_c) begin
              dcnt_q <= dcnt_q + DEAD_W'(1);
            end else begin
              state_q <= ACTIVE;
              cnt_q   <= '0;
              div_q   <= div_i;
              dead_q  <= dead_i;
              phi_q   <= NUM_PHASES'(onehot(OH_IDX_W'(idx_q)));
            end
          end
        end
        default: begin
          state_q <= IDLE;
          phi_q   <= '0;
        end
      endcase
    end
  end

  ssp_clear_stretch #(
    .STRETCH (CLEAR_STRETCH)
  ) u_clear_stretch (
    .clk_i   (clk_i),
    .clear_i (clear_i),
    .clear_o (clear_o)
  );

  assign phi_o        = phi_q;
  assign phase_idx_o  = idx_q;
  assign cycle_done_o = done_q;
  assign stalled_o    = stalled_q;
  assign clk_o        = clk_i;

endmodule : ssp_phase_gen
